// File: rtl/hazard_bubble_stage_pkg.sv
// Shared definitions for the ID/EX control-path register: control-word layout,
// default NOP encoding and the bubble sequencer state type.
package hazard_bubble_stage_pkg;

    localparam int CTRL_W_DEF = 8;

    // Bit positions inside {RegDst, ALUOp[1:0], ALUSrc, RegWrite, MemToReg, MemRead, MemWrite}
    localparam int CTRL_REGDST   = 7;
    localparam int CTRL_ALUOP_HI = 6;
    localparam int CTRL_ALUOP_LO = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 0;

    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL_DEF = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_bubble_stage_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_bubble_stage.sv
// ID/EX control register with load-use bubble insertion, branch flush,
// downstream hold and a multi-cycle stall sequencer.
module hazard_bubble_stage
    import hazard_bubble_stage_pkg::*;
#(
    parameter int                CTRL_W       = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] NOP_CTRL     = {CTRL_W{1'b0}},
    parameter int                STALL_CYCLES = 1,
    parameter int                CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              valid_i,
    input  logic              hazard_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              valid_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // Remaining bubbles after the one inserted on the hazard edge itself.
    localparam logic [3:0] SC_INIT = 4'(STALL_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        sc_q, sc_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic              bubble_inc;
    logic              flush_inc;

    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        ctrl_d     = ctrl_q;
        valid_d    = valid_q;
        bubble_inc = 1'b0;
        flush_inc  = 1'b0;
        if (!hold_i) begin
            if (flush_i) begin
                ctrl_d    = NOP_CTRL;
                valid_d   = 1'b0;
                flush_inc = 1'b1;
                sc_d      = 4'd0;
                state_d   = RUN;
            end else if (state_q == STALL) begin
                ctrl_d     = NOP_CTRL;
                valid_d    = 1'b0;
                bubble_inc = 1'b1;
                sc_d       = sc_q - 4'd1;
                if (sc_q == 4'd1)
                    state_d = RUN;
            end else if (valid_i && hazard_i) begin
                ctrl_d     = NOP_CTRL;
                valid_d    = 1'b0;
                bubble_inc = 1'b1;
                if (STALL_CYCLES > 1) begin
                    sc_d    = SC_INIT;
                    state_d = STALL;
                end
            end else begin
                ctrl_d  = valid_i ? ctrl_i : NOP_CTRL;
                valid_d = valid_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            sc_q    <= 4'd0;
            ctrl_q  <= NOP_CTRL;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign stall_o = hold_i | (state_q == STALL) |
                     ((state_q == RUN) & valid_i & hazard_i & ~flush_i);
    assign ctrl_o  = ctrl_q;
    assign valid_o = valid_q;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (bubble_inc),
        .cnt_o (bubble_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_bubble_stage.sv
// Directed bench: three instances (single-bubble, 3-cycle stall, 2-bit counters)
// share one stimulus bus and are checked phase by phase.
module tb_hazard_bubble_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ctrl_i;
    logic       valid_i, hazard_i, flush_i, hold_i;

    logic [7:0]  a_ctrl, b_ctrl, c_ctrl;
    logic        a_valid, b_valid, c_valid;
    logic        a_stall, b_stall, c_stall;
    logic [15:0] a_bcnt, a_fcnt, b_bcnt, b_fcnt;
    logic [1:0]  c_bcnt, c_fcnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_bubble_stage #(.STALL_CYCLES(1), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl_i), .valid_i(valid_i),
        .hazard_i(hazard_i), .flush_i(flush_i), .hold_i(hold_i),
        .ctrl_o(a_ctrl), .valid_o(a_valid), .stall_o(a_stall),
        .bubble_cnt_o(a_bcnt), .flush_cnt_o(a_fcnt));

    hazard_bubble_stage #(.STALL_CYCLES(3), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl_i), .valid_i(valid_i),
        .hazard_i(hazard_i), .flush_i(flush_i), .hold_i(hold_i),
        .ctrl_o(b_ctrl), .valid_o(b_valid), .stall_o(b_stall),
        .bubble_cnt_o(b_bcnt), .flush_cnt_o(b_fcnt));

    hazard_bubble_stage #(.STALL_CYCLES(1), .CNT_W(2)) u_c (
        .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl_i), .valid_i(valid_i),
        .hazard_i(hazard_i), .flush_i(flush_i), .hold_i(hold_i),
        .ctrl_o(c_ctrl), .valid_o(c_valid), .stall_o(c_stall),
        .bubble_cnt_o(c_bcnt), .flush_cnt_o(c_fcnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ctrl_i = 8'h00; valid_i = 1'b0; hazard_i = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] pass_vec [4];

    initial begin
        pass_vec[0] = 8'hA5; pass_vec[1] = 8'h3C; pass_vec[2] = 8'h81; pass_vec[3] = 8'h42;

        // Reset state, observed before any clock edge
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst_ctrl",  {24'd0, a_ctrl}, 32'h00);
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_bcnt",  {16'd0, a_bcnt}, 32'd0);
        chk("rst_fcnt",  {16'd0, a_fcnt}, 32'd0);
        chk("rst_stall", {31'd0, b_stall}, 32'd0);
        tick();
        rst = 1'b0;

        // Pass-through
        for (int i = 0; i < 4; i++) begin
            ctrl_i = pass_vec[i]; valid_i = 1'b1;
            #1;
            chk("pt_stall", {31'd0, a_stall}, 32'd0);
            tick();
            chk("pt_ctrl",  {24'd0, a_ctrl}, {24'd0, pass_vec[i]});
            chk("pt_valid", {31'd0, a_valid}, 32'd1);
        end
        chk("pt_bcnt", {16'd0, a_bcnt}, 32'd0);
        chk("pt_fcnt", {16'd0, a_fcnt}, 32'd0);
        valid_i = 1'b0;
        tick();
        chk("pt_invalid_nop", {24'd0, a_ctrl}, 32'h00);

        // Single bubble
        do_reset();
        ctrl_i = 8'h5A; valid_i = 1'b1; hazard_i = 1'b1;
        #1;
        chk("sb_stall", {31'd0, a_stall}, 32'd1);
        tick();
        chk("sb_nop",   {24'd0, a_ctrl}, 32'h00);
        chk("sb_valid", {31'd0, a_valid}, 32'd0);
        chk("sb_bcnt",  {16'd0, a_bcnt}, 32'd1);
        hazard_i = 1'b0;
        #1;
        chk("sb_stall_rel", {31'd0, a_stall}, 32'd0);
        tick();
        chk("sb_replay", {24'd0, a_ctrl}, 32'h5A);
        chk("sb_replay_v", {31'd0, a_valid}, 32'd1);
        // Hold in RUN freezes the registered word
        ctrl_i = 8'h99; hold_i = 1'b1;
        #1;
        chk("hr_stall", {31'd0, a_stall}, 32'd1);
        tick();
        chk("hr_ctrl", {24'd0, a_ctrl}, 32'h5A);
        hold_i = 1'b0;

        // Multi-cycle stall, STALL_CYCLES=3
        do_reset();
        ctrl_i = 8'h77; valid_i = 1'b1; hazard_i = 1'b1;
        #1;
        chk("mc_stall0", {31'd0, b_stall}, 32'd1);
        tick();
        hazard_i = 1'b0;
        chk("mc_nop1",  {24'd0, b_ctrl}, 32'h00);
        chk("mc_bcnt1", {16'd0, b_bcnt}, 32'd1);
        chk("mc_stall1", {31'd0, b_stall}, 32'd1);
        tick();
        chk("mc_nop2",  {24'd0, b_ctrl}, 32'h00);
        chk("mc_bcnt2", {16'd0, b_bcnt}, 32'd2);
        chk("mc_stall2", {31'd0, b_stall}, 32'd1);
        tick();
        chk("mc_nop3",  {24'd0, b_ctrl}, 32'h00);
        chk("mc_valid3", {31'd0, b_valid}, 32'd0);
        chk("mc_bcnt3", {16'd0, b_bcnt}, 32'd3);
        chk("mc_run",   {31'd0, b_stall}, 32'd0);
        tick();
        chk("mc_replay", {24'd0, b_ctrl}, 32'h77);
        chk("mc_bcnt_end", {16'd0, b_bcnt}, 32'd3);

        // Flush beats a simultaneous hazard
        do_reset();
        ctrl_i = 8'h5A; valid_i = 1'b1; hazard_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("fp_stall", {31'd0, a_stall}, 32'd0);
        tick();
        chk("fp_ctrl",  {24'd0, a_ctrl}, 32'h00);
        chk("fp_valid", {31'd0, a_valid}, 32'd0);
        chk("fp_fcnt",  {16'd0, a_fcnt}, 32'd1);
        chk("fp_bcnt",  {16'd0, a_bcnt}, 32'd0);
        chk("fp_b_bcnt", {16'd0, b_bcnt}, 32'd0);
        chk("fp_b_stall", {31'd0, b_stall}, 32'd0);

        // Flush aborting a 3-cycle stall after two bubbles
        do_reset();
        ctrl_i = 8'h33; valid_i = 1'b1; hazard_i = 1'b1;
        tick();
        hazard_i = 1'b0;
        tick();
        chk("fa_bcnt_pre", {16'd0, b_bcnt}, 32'd2);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fa_bcnt", {16'd0, b_bcnt}, 32'd2);
        chk("fa_fcnt", {16'd0, b_fcnt}, 32'd1);
        chk("fa_run",  {31'd0, b_stall}, 32'd0);
        tick();
        chk("fa_pass", {24'd0, b_ctrl}, 32'h33);

        // Hold mid-stall
        do_reset();
        ctrl_i = 8'h66; valid_i = 1'b1; hazard_i = 1'b1;
        tick();
        hazard_i = 1'b0; hold_i = 1'b1; ctrl_i = 8'hEE;
        tick();
        chk("hd_ctrl1", {24'd0, b_ctrl}, 32'h00);
        chk("hd_bcnt1", {16'd0, b_bcnt}, 32'd1);
        chk("hd_stall1", {31'd0, b_stall}, 32'd1);
        tick();
        chk("hd_bcnt2", {16'd0, b_bcnt}, 32'd1);
        hold_i = 1'b0; ctrl_i = 8'h66;
        #1;
        chk("hd_stall_rel", {31'd0, b_stall}, 32'd1);
        tick();
        chk("hd_bcnt3", {16'd0, b_bcnt}, 32'd2);
        chk("hd_stall3", {31'd0, b_stall}, 32'd1);
        tick();
        chk("hd_bcnt4", {16'd0, b_bcnt}, 32'd3);
        chk("hd_run",   {31'd0, b_stall}, 32'd0);

        // Saturation with 2-bit counters
        do_reset();
        ctrl_i = 8'h11; valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            hazard_i = 1'b1;
            tick();
            hazard_i = 1'b0;
            tick();
        end
        chk("sat_bcnt", {30'd0, c_bcnt}, 32'd3);
        chk("sat_fcnt", {30'd0, c_fcnt}, 32'd0);

        // Asynchronous reset between edges while in STALL
        do_reset();
        ctrl_i = 8'h22; valid_i = 1'b1; hazard_i = 1'b1;
        tick();
        hazard_i = 1'b0;
        chk("ar_pre_stall", {31'd0, b_stall}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_stall", {31'd0, b_stall}, 32'd0);
        chk("ar_bcnt",  {16'd0, b_bcnt}, 32'd0);
        chk("ar_ctrl",  {24'd0, b_ctrl}, 32'h00);
        chk("ar_valid", {31'd0, b_valid}, 32'd0);
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
